// File: rtl/cpu_sequencer_pkg.sv
// Shared opcode and state encodings for the accumulator CPU sequencer.
// The datapath/IR decode imports the same definitions.
package cpu_sequencer_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_HLT  = 3'd0;
    localparam logic [OPW-1:0] OP_SKZ  = 3'd1;
    localparam logic [OPW-1:0] OP_ADD  = 3'd2;
    localparam logic [OPW-1:0] OP_ANDD = 3'd3;
    localparam logic [OPW-1:0] OP_XORR = 3'd4;
    localparam logic [OPW-1:0] OP_LDA  = 3'd5;
    localparam logic [OPW-1:0] OP_STO  = 3'd6;
    localparam logic [OPW-1:0] OP_JMP  = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_S0     = 4'd1,
        ST_S1     = 4'd2,
        ST_S2     = 4'd3,
        ST_S3     = 4'd4,
        ST_S4     = 4'd5,
        ST_S5     = 4'd6,
        ST_S6     = 4'd7,
        ST_S7     = 4'd8,
        ST_HALTED = 4'd9
    } state_t;

endpackage

// File: rtl/cpu_sequencer_seq_op_decode.sv
// Combinational opcode class decode used by the sequencer strobe logic.
module seq_op_decode
    import cpu_sequencer_pkg::*;
(
    input  logic [OPW-1:0] op_i,
    output logic           is_alu_o,
    output logic           is_sto_o,
    output logic           is_jmp_o,
    output logic           is_skz_o,
    output logic           is_hlt_o
);

    assign is_alu_o = (op_i == OP_ADD) || (op_i == OP_ANDD) ||
                      (op_i == OP_XORR) || (op_i == OP_LDA);
    assign is_sto_o = (op_i == OP_STO);
    assign is_jmp_o = (op_i == OP_JMP);
    assign is_skz_o = (op_i == OP_SKZ);
    assign is_hlt_o = (op_i == OP_HLT);

endmodule

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction-cycle controller: state register, opcode/zero capture
// and registered control strobes for the accumulator CPU datapath.
//
//  state  | meaning
//  IDLE   | waiting for fetch after reset
//  S0/S1  | fetch high / low IR byte
//  S2     | IR settling, opcode/zero captured on exit
//  S3     | halt decision
//  S4-S6  | operand access / execute
//  S7     | end of cycle, back to S0
//  HALTED | sticky halt until reset
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int OPW_P = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch,
    input  logic [OPW_P-1:0] opcode,
    input  logic             zero,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             rd,
    output logic             wr,
    output logic             datactl_ena,
    output logic             load_acc,
    output logic             halt
);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           zero_q, zero_d;
    logic           load_ir_d, inc_pc_d, load_pc_d, rd_d, wr_d;
    logic           datactl_ena_d, load_acc_d, halt_d;
    logic           is_alu, is_sto, is_jmp, is_skz, is_hlt;

    // Decode the op that will be held next cycle so S3 strobes see the fresh capture.
    seq_op_decode u_dec (
        .op_i     (op_d),
        .is_alu_o (is_alu),
        .is_sto_o (is_sto),
        .is_jmp_o (is_jmp),
        .is_skz_o (is_skz),
        .is_hlt_o (is_hlt)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE:   if (fetch) state_d = ST_S0;
            ST_S0:     state_d = ST_S1;
            ST_S1:     state_d = ST_S2;
            ST_S2: begin
                state_d = ST_S3;
                op_d    = opcode[OPW-1:0];
                zero_d  = zero;
            end
            ST_S3:     state_d = is_hlt ? ST_HALTED : ST_S4;
            ST_S4:     state_d = ST_S5;
            ST_S5:     state_d = ST_S6;
            ST_S6:     state_d = ST_S7;
            ST_S7:     state_d = ST_S0;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ir_d     = 1'b0;
        inc_pc_d      = 1'b0;
        load_pc_d     = 1'b0;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        datactl_ena_d = 1'b0;
        load_acc_d    = 1'b0;
        halt_d        = 1'b0;
        case (state_d)
            ST_S0, ST_S1: begin
                load_ir_d = 1'b1;
                rd_d      = 1'b1;
                inc_pc_d  = 1'b1;
            end
            ST_S3:     halt_d = is_hlt;
            ST_S4: begin
                rd_d          = is_alu;
                datactl_ena_d = is_sto;
                load_pc_d     = is_jmp;
                inc_pc_d      = is_skz & zero_d;
            end
            ST_S5: begin
                rd_d          = is_alu;
                load_acc_d    = is_alu;
                datactl_ena_d = is_sto;
                wr_d          = is_sto;
                load_pc_d     = is_jmp;
            end
            ST_S6:     datactl_ena_d = is_sto;
            ST_HALTED: halt_d = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            zero_q      <= 1'b0;
            load_ir     <= 1'b0;
            inc_pc      <= 1'b0;
            load_pc     <= 1'b0;
            rd          <= 1'b0;
            wr          <= 1'b0;
            datactl_ena <= 1'b0;
            load_acc    <= 1'b0;
            halt        <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            zero_q      <= zero_d;
            load_ir     <= load_ir_d;
            inc_pc      <= inc_pc_d;
            load_pc     <= load_pc_d;
            rd          <= rd_d;
            wr          <= wr_d;
            datactl_ena <= datactl_ena_d;
            load_acc    <= load_acc_d;
            halt        <= halt_d;
        end
    end

endmodule
